// File: rtl/muldiv_controller.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, UNROLL bits per cycle.
// Optional MULDIV_EARLY_OUT_EN: single-cycle completion for |A|<|B| divides and multiplies by zero.
module muldiv_controller #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic            Flush,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic              busy_r, done_r;
  logic [2:0]        op_r;
  logic              neg_r, rneg_r;
  logic [XLEN-1:0]   m_r;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [CW-1:0]     cnt;

  // Operand decode at the accept edge
  logic            is_m, accept, is_div, a_signed, b_signed, sa, sb, div0, ovf;
  logic [XLEN-1:0] ma, mb;

  assign is_m     = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign accept   = Start && is_m && !busy_r && !Flush;
  assign is_div   = Funct3[2];
  assign a_signed = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign b_signed = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign sa       = a_signed && SrcA[XLEN-1];
  assign sb       = b_signed && SrcB[XLEN-1];
  assign ma       = sa ? -SrcA : SrcA;
  assign mb       = sb ? -SrcB : SrcB;
  assign div0     = (SrcB == '0);
  assign ovf      = ((Funct3 == 3'b100) || (Funct3 == 3'b110)) &&
                    (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);

  logic            short_path;
  logic [XLEN-1:0] short_res;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    short_path = 1'b0;
    short_res  = '0;
    if (is_div && div0) begin
      short_path = 1'b1;
      short_res  = Funct3[1] ? SrcA : '1;
    end else if (is_div && ovf) begin
      short_path = 1'b1;
      short_res  = Funct3[1] ? '0 : SrcA;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (is_div && (ma < mb)) begin
      short_path = 1'b1;
      short_res  = Funct3[1] ? SrcA : '0;
    end else if (!is_div && ((SrcA == '0) || (SrcB == '0))) begin
      short_path = 1'b1;
      short_res  = '0;
    end
`endif
  end

  // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic [XLEN:0] sum, rs, diff;

  always_comb begin
    acc_next = acc;
    sum      = '0;
    rs       = '0;
    diff     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_r[2]) begin
        rs   = {acc_next[2*XLEN-1:XLEN], acc_next[XLEN-1]};
        diff = rs - {1'b0, m_r};
        if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc_next[XLEN-2:0], 1'b1};
        else             acc_next = {rs[XLEN-1:0], acc_next[XLEN-2:0], 1'b0};
      end else begin
        sum      = {1'b0, acc_next[2*XLEN-1:XLEN]} + (acc_next[0] ? {1'b0, m_r} : '0);
        acc_next = {sum, acc_next[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, calc_res;

  always_comb begin
    prod = neg_r ? -acc_next : acc_next;
    quot = acc_next[XLEN-1:0];
    remv = acc_next[2*XLEN-1:XLEN];
    if (op_r[2])
      calc_res = op_r[1] ? (rneg_r ? -remv : remv) : (neg_r ? -quot : quot);
    else
      calc_res = (op_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      Result <= '0;
      op_r   <= '0;
      neg_r  <= 1'b0;
      rneg_r <= 1'b0;
      m_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (Flush) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r   <= Funct3;
          neg_r  <= sa ^ sb;
          rneg_r <= sa;
          cnt    <= '0;
          busy_r <= 1'b1;
          if (short_path) begin
            state  <= DONE;
            done_r <= 1'b1;
            Result <= short_res;
          end else begin
            state <= CALC;
            m_r   <= is_div ? mb : ma;
            acc   <= is_div ? {{XLEN{1'b0}}, ma} : {{XLEN{1'b0}}, mb};
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state  <= DONE;
            done_r <= 1'b1;
            Result <= calc_res;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  // A flush landing in the DONE cycle suppresses that cycle's pulse
  assign Done = done_r && !Flush;

endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
- Multi-cycle RV32M/RV64M execute block. It decodes ALUOp/Funct7/Funct3 the same way the ALU controller does, and extends that decode to the M-extension opcodes.
- Runs an iterative shift-add multiply and a restoring divide, UNROLL bits per cycle.
- Sits in EX beside the single-cycle ALU. Busy stalls the pipeline; Flush aborts the operation on a branch or exception.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- UNROLL, 1, bits retired per iteration cycle; 1, 2 or 4; must divide XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  operation request from EX (qualified by decode)
- Flush  input  1  synchronous abort of any in-flight operation
- ALUOp  input  2  controller opcode class; 2'b10 = R/I-type
- Funct7  input  7  instruction bits 31:25
- Funct3  input  3  instruction bits 14:12
- SrcA  input  XLEN  rs1 operand (multiplicand/dividend)
- SrcB  input  XLEN  rs2 operand (multiplier/divisor)
- Busy  output  1  high whenever state != IDLE
- Done  output  1  one-cycle pulse; Result valid
- Result  output  XLEN  registered result, held until next accept

Behaviour:
- Reset (rst_n low, async): state=IDLE, Busy=0, Done=0, Result=0, all datapath regs cleared. Reset mid-operation discards the operation with no Done.
- Decode: IsM = (ALUOp==2'b10 && Funct7==7'b0000001). Funct3 selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept = Start && IsM && !Busy && !Flush. Operands and op are latched at the accept edge.
- Start while Busy, or Start with !IsM: ignored, no state change.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept when the operation is a special divide.
  - CALC counts N = XLEN/UNROLL cycles, then goes to DONE.
  - DONE -> IDLE unconditionally.
- Done=1 only in DONE.
- Latency: Done is high in cycle N+1 after the accept cycle (33 for XLEN=32, UNROLL=1), and in cycle 1 for special divides.
- Multiply: operate on magnitudes; signedness per op (MULHSU: SrcA signed, SrcB unsigned). Accumulate a 2*XLEN product.
  - Negate the product if the signs differ; this fix is registered on the CALC->DONE edge.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide: restoring algorithm on magnitudes.
  - Quotient sign = sign(A) xor sign(B) (signed ops only).
  - Remainder takes the sign of the dividend.
- Special divides (no CALC):
  - divisor==0: DIV/DIVU -> all ones; REM/REMU -> SrcA.
  - signed overflow (SrcA=most-negative, SrcB=-1): DIV -> SrcA; REM -> 0.
- Flush:
  - In CALC or DONE: next state IDLE, Done forced 0 that cycle, Result unchanged.
  - Flush with Start in the same cycle: Flush wins and Start is ignored.
- Result updates only on entry to DONE.
- Back-to-back: a new accept is possible in the cycle after DONE (IDLE).

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - Unsigned-magnitude |A| < |B| divides go IDLE->DONE in 1 cycle (quotient 0, remainder SrcA).
  - Multiplies with either operand == 0 go IDLE->DONE with Result 0.
- Undefined: only div-by-zero and overflow take the short path; every other operation costs N+1 cycles. Results are identical either way; only latency differs.

Test Plan (XLEN=32, UNROLL=1, macro undefined unless noted):
1. MUL SrcA=7, SrcB=0xFFFFFFFD -> Result=0xFFFFFFEB; Done exactly 33 cycles after accept; Busy high cycles 1..33.
2. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed divide of SrcA=0xFFFFFFF9 (-7) by SrcB=2:
   - DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Special divides, each with Done 1 cycle after accept:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same operands -> 0.
5. Abort and ignored requests:
   - Flush on cycle 10 of a DIV -> Busy=0 next cycle, no Done pulse, Result keeps its previous value.
   - Start while Busy -> ignored.
   - Start with ALUOp=2'b00 -> ignored.
   - rst_n low mid-CALC -> all outputs 0 immediately.
6. With MULDIV_EARLY_OUT_EN defined:
   - DIVU 3/10 -> 0 in 1 cycle; REMU 3/10 -> 3.
   - MUL 0*0x1234 -> 0 in 1 cycle.
   - Regress scenarios 1-4 with identical results.
